// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU data-memory responder.
// Optional access-fault reporting is enabled by defining DMEM_ERR_EN.
package cpu_mem_pkg;

    localparam int DMEM_DATA_WIDTH = 64;
    localparam int WORD_BYTES      = DMEM_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } dmem_op_t;

    // A simultaneous read and write is resolved as a write.
    function automatic dmem_op_t dmem_decode_op(input logic rd, input logic wr);
        dmem_op_t op;
        op = rd ? OP_READ : OP_READ;
        if (wr) begin
            op = OP_WRITE;
        end
        return op;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered, enable-gated read port.
// Contents are never reset; only the read register is.
module dmem_array
    import cpu_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Word storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= wdata;
        end
    end

    // Read register only updates on a read so the last value is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            r_rdata <= r_mem[idx];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the CPU data-memory interface: one access at a time with
// programmable wait states. Fault reporting is compiled in with DMEM_ERR_EN.
module dmem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_WIDTH    = 64,
    parameter int DEPTH         = 1024,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [DATA_WIDTH-1:0] dmem_write_data,
    input  logic                  dmem_read,
    input  logic                  dmem_write,
    output logic [DATA_WIDTH-1:0] dmem_read_data,
    output logic                  dmem_ready,
    output logic                  dmem_error
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int IDX_LSB = $clog2(WORD_BYTES);
    localparam int IDX_MSB = IDX_LSB + IDX_W - 1;
    localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

    dmem_state_t           r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    dmem_op_t              r_op;
    logic                  r_ready;
    logic                  r_err;
    logic                  r_rd_zero;

    dmem_state_t           w_next_state;
    logic [3:0]            w_cnt_next;
    logic [3:0]            w_load;
    logic                  w_accept;
    logic                  w_to_done;
    dmem_op_t              w_op;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_fault;
    logic                  w_we;
    logic                  w_re;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Next-state logic; in IDLE the live request is used so latency 1 completes directly.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 4'd0;
        w_accept     = 1'b0;
        w_to_done    = 1'b0;
        w_op         = r_op;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        case (r_state)
            IDLE: begin
                w_op    = dmem_decode_op(dmem_read, dmem_write);
                w_addr  = dmem_addr;
                w_wdata = dmem_write_data;
                if (dmem_read || dmem_write) begin
                    w_accept = 1'b1;
                    w_load   = (w_op == OP_WRITE) ? WR_LOAD : RD_LOAD;
                    if (w_load == 4'd0) begin
                        w_next_state = DONE;
                        w_to_done    = 1'b1;
                        w_cnt_next   = 4'd0;
                    end else begin
                        w_next_state = BUSY;
                        w_cnt_next   = w_load;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            BUSY: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_next_state = DONE;
                    w_to_done    = 1'b1;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_next_state = BUSY;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

`ifdef DMEM_ERR_EN
    assign w_fault = (|w_addr[IDX_LSB-1:0]) || (|w_addr[ADDR_WIDTH-1:IDX_MSB+1]);
`else
    logic w_unused_addr;
    assign w_fault       = 1'b0;
    assign w_unused_addr = ^{w_addr[ADDR_WIDTH-1:IDX_MSB+1], w_addr[IDX_LSB-1:0]};
`endif

    // Memory side effects happen on the edge that enters DONE, never during reset.
    assign w_we = w_to_done && (w_op == OP_WRITE) && !w_fault && !reset;
    assign w_re = w_to_done && (w_op == OP_READ) && !reset;

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (w_we),
        .re    (w_re),
        .idx   (w_addr[IDX_MSB:IDX_LSB]),
        .wdata (w_wdata),
        .rdata (w_rdata)
    );

    // State, wait counter, request latch and completion flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= {ADDR_WIDTH{1'b0}};
            r_wdata   <= {DATA_WIDTH{1'b0}};
            r_op      <= OP_READ;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_rd_zero <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_ready <= w_to_done;
            r_err   <= w_to_done && w_fault;
            if (w_accept) begin
                r_addr  <= dmem_addr;
                r_wdata <= dmem_write_data;
                r_op    <= w_op;
            end
            if (w_re) begin
                r_rd_zero <= w_fault;
            end
        end
    end

    // A faulting read reports zero data until the next read completes.
    assign dmem_read_data = r_rd_zero ? {DATA_WIDTH{1'b0}} : w_rdata;
    assign dmem_ready     = r_ready;
    assign dmem_error     = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: four instances with different
// latencies, a transaction-level model and directed literal checks.
module tb_dmem_responder;

    localparam int NI    = 4;
    localparam int DEPTH = 1024;
    localparam int RL [NI] = '{2, 1, 4, 15};
    localparam int WL [NI] = '{1, 1, 3, 15};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] in_addr  [NI];
    logic [63:0] in_wdata [NI];
    logic        in_rd    [NI];
    logic        in_wr    [NI];
    logic [63:0] o_rdata  [NI];
    logic        o_rdy    [NI];
    logic        o_err    [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gen_dut
        dmem_responder #(
            .ADDR_WIDTH    (64),
            .DATA_WIDTH    (64),
            .DEPTH         (DEPTH),
            .READ_LATENCY  (RL[g]),
            .WRITE_LATENCY (WL[g])
        ) u_dut (
            .clk             (clk),
            .reset           (rst),
            .dmem_addr       (in_addr[g]),
            .dmem_write_data (in_wdata[g]),
            .dmem_read       (in_rd[g]),
            .dmem_write      (in_wr[g]),
            .dmem_read_data  (o_rdata[g]),
            .dmem_ready      (o_rdy[g]),
            .dmem_error      (o_err[g])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit cmp_on   = 1'b0;

    // Model state: word contents, pending completion and the held read data.
    logic [63:0] mdl_mem [int];
    int          exp_cyc    [NI];
    bit          pend_rd    [NI];
    bit          pend_err   [NI];
    logic [63:0] pend_rdata [NI];
    logic [63:0] exp_rdata  [NI];
    bit          watch      [NI];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit mdl_fault(input logic [63:0] a);
`ifdef DMEM_ERR_EN
        return (a % 64'd8 != 64'd0) || (a >= 64'(DEPTH * 8));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int mdl_key(input int i, input logic [63:0] a);
        return i * DEPTH + int'((a / 64'd8) % 64'(DEPTH));
    endfunction

    // Per-cycle comparison of every watched instance against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < NI; i++) begin
                if (watch[i]) begin
                    logic rdy_e, err_e;
                    rdy_e = 1'b0;
                    err_e = 1'b0;
                    if (cyc == exp_cyc[i]) begin
                        rdy_e = 1'b1;
                        err_e = pend_err[i];
                        if (pend_rd[i]) exp_rdata[i] = pend_rdata[i];
                    end
                    chk($sformatf("ready[%0d]", i), {63'd0, o_rdy[i]}, {63'd0, rdy_e});
                    chk($sformatf("error[%0d]", i), {63'd0, o_err[i]}, {63'd0, err_e});
                    chk($sformatf("rdata[%0d]", i), o_rdata[i], exp_rdata[i]);
                end
            end
        end
    end

    // One transaction; optionally changes address/data right after acceptance.
    task automatic xact(input int i, input bit rd, input bit wr,
                        input logic [63:0] a, input logic [63:0] d,
                        input bit chg, input logic [63:0] a2, input logic [63:0] d2,
                        output int lat, output logic obs_err, output logic [63:0] obs_data);
        int acc, L, key;
        bit f;
        @(negedge clk);
        in_rd[i] = rd; in_wr[i] = wr; in_addr[i] = a; in_wdata[i] = d;
        @(posedge clk); #1;
        acc = cyc;
        L   = wr ? WL[i] : RL[i];
        f   = mdl_fault(a);
        key = mdl_key(i, a);
        pend_err[i] = f;
        pend_rd[i]  = !wr;
        if (wr) begin
            if (!f) mdl_mem[key] = d;
        end else begin
            pend_rdata[i] = f ? 64'd0 : (mdl_mem.exists(key) ? mdl_mem[key] : 64'd0);
        end
        exp_cyc[i] = acc + L - 1;
        lat = -1; obs_err = 1'b0; obs_data = 64'd0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_rdy[i]) begin
                lat = cyc - acc + 1; obs_err = o_err[i]; obs_data = o_rdata[i];
                break;
            end else if (k == 0 && chg) begin
                in_addr[i] = a2; in_wdata[i] = d2;
            end
        end
        in_rd[i] = 1'b0; in_wr[i] = 1'b0;
        if (lat < 0) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic e;
        logic [63:0] rd;
        logic [4:0] pat;
        for (int i = 0; i < NI; i++) begin
            in_addr[i] = 64'd0; in_wdata[i] = 64'd0; in_rd[i] = 1'b0; in_wr[i] = 1'b0;
            exp_cyc[i] = -100; exp_rdata[i] = 64'd0; watch[i] = 1'b1;
            pend_rd[i] = 1'b0; pend_err[i] = 1'b0; pend_rdata[i] = 64'd0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", {63'd0, o_rdy[0]}, 64'd0);
        chk("reset_rdata", o_rdata[0], 64'd0);
        chk("reset_error", {63'd0, o_err[0]}, 64'd0);
        cmp_on = 1'b1;

        // Write then read with default latencies.
        xact(0, 1'b0, 1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D, 1'b0, 64'd0, 64'd0, lat, e, rd);
        chk("wr_lat_default", 64'(lat), 64'd1);
        xact(0, 1'b1, 1'b0, 64'h40, 64'd0, 1'b0, 64'd0, 64'd0, lat, e, rd);
        chk("rd_lat_default", 64'(lat), 64'd2);
        chk("rd_data_0x40", rd, 64'hDEADBEEF_CAFEF00D);

        // Latency sweep on the other instances.
        for (int i = 1; i < NI; i++) begin
            xact(i, 1'b0, 1'b1, 64'h100, 64'h1111_0000 + 64'(i), 1'b0, 64'd0, 64'd0, lat, e, rd);
            chk($sformatf("wr_lat[%0d]", i), 64'(lat), 64'(WL[i]));
            xact(i, 1'b1, 1'b0, 64'h100, 64'd0, 1'b0, 64'd0, 64'd0, lat, e, rd);
            chk($sformatf("rd_data[%0d]", i), rd, 64'h1111_0000 + 64'(i));
        end
        xact(1, 1'b1, 1'b0, 64'h100, 64'd0, 1'b0, 64'd0, 64'd0, lat, e, rd);
        chk("rd_lat_1", 64'(lat), 64'd1);
        xact(2, 1'b1, 1'b0, 64'h100, 64'd0, 1'b0, 64'd0, 64'd0, lat, e, rd);
        chk("rd_lat_4", 64'(lat), 64'd4);
        xact(3, 1'b1, 1'b0, 64'h100, 64'd0, 1'b0, 64'd0, 64'd0, lat, e, rd);
        chk("rd_lat_15", 64'(lat), 64'd15);

        // Inputs changed while busy must not affect the committed write.
        xact(2, 1'b0, 1'b1, 64'h28, 64'hB0B0, 1'b0, 64'd0, 64'd0, lat, e, rd);
        xact(2, 1'b0, 1'b1, 64'h20, 64'hC0C0, 1'b1, 64'h28, 64'hD0D0, lat, e, rd);
        xact(2, 1'b1, 1'b0, 64'h20, 64'd0, 1'b0, 64'd0, 64'd0, lat, e, rd);
        chk("latched_data_0x20", rd, 64'hC0C0);
        xact(2, 1'b1, 1'b0, 64'h28, 64'd0, 1'b0, 64'd0, 64'd0, lat, e, rd);
        chk("untouched_0x28", rd, 64'hB0B0);

        // Read and write together resolve as a write.
        xact(0, 1'b1, 1'b1, 64'h8, 64'h55, 1'b0, 64'd0, 64'd0, lat, e, rd);
        chk("rdwr_lat", 64'(lat), 64'd1);
        chk("rdwr_rdata_held", rd, 64'hDEADBEEF_CAFEF00D);
        xact(0, 1'b1, 1'b0, 64'h8, 64'd0, 1'b0, 64'd0, 64'd0, lat, e, rd);
        chk("rdwr_readback", rd, 64'h55);

        // Held request: pulses separated by at least one idle cycle.
        xact(1, 1'b0, 1'b1, 64'h48, 64'hB2B, 1'b0, 64'd0, 64'd0, lat, e, rd);
        watch[1] = 1'b0;
        @(negedge clk);
        in_rd[1] = 1'b1; in_addr[1] = 64'h48;
        pat = 5'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            pat = {pat[3:0], o_rdy[1]};
        end
        in_rd[1] = 1'b0;
        chk("b2b_pattern", {59'd0, pat}, 64'h15);
        chk("b2b_data", o_rdata[1], 64'hB2B);
        exp_rdata[1] = 64'hB2B;
        @(negedge clk);
        watch[1] = 1'b1;

        // Reset while a write to 0x10 is busy.
        xact(2, 1'b0, 1'b1, 64'h10, 64'h0123, 1'b0, 64'd0, 64'd0, lat, e, rd);
        @(negedge clk);
        in_wr[2] = 1'b1; in_addr[2] = 64'h10; in_wdata[2] = 64'hBAD;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1; in_wr[2] = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NI; i++) exp_rdata[i] = 64'd0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        xact(2, 1'b1, 1'b0, 64'h10, 64'd0, 1'b0, 64'd0, 64'd0, lat, e, rd);
        chk("reset_drop_0x10", rd, 64'h0123);

        // Misaligned and out-of-range accesses.
        xact(0, 1'b0, 1'b1, 64'h0, 64'h77, 1'b0, 64'd0, 64'd0, lat, e, rd);
        xact(0, 1'b1, 1'b0, 64'h3, 64'd0, 1'b0, 64'd0, 64'd0, lat, e, rd);
`ifdef DMEM_ERR_EN
        chk("misaligned_err", {63'd0, e}, 64'd1);
        chk("misaligned_data", rd, 64'd0);
`else
        chk("misaligned_err", {63'd0, e}, 64'd0);
        chk("misaligned_wrap", rd, 64'h77);
`endif
        xact(0, 1'b0, 1'b1, 64'h2000, 64'h99, 1'b0, 64'd0, 64'd0, lat, e, rd);
        xact(0, 1'b1, 1'b0, 64'h0, 64'd0, 1'b0, 64'd0, 64'd0, lat, e, rd);
`ifdef DMEM_ERR_EN
        chk("oor_write_blocked", rd, 64'h77);
`else
        chk("oor_write_wraps", rd, 64'h99);
`endif

        repeat (3) @(negedge clk);
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
